// File: rtl/cpu_thread_sched_pkg.sv
// Shared constants and state type for the sha512crypt CPU thread scheduler.
package cpu_thread_sched_pkg;

  localparam int SCHED_N_THREADS = 4;
  localparam int SCHED_THREAD_W  = $clog2(SCHED_N_THREADS);
  localparam int SCHED_CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RELOAD   = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_RUN      = 3'd3,
    ST_FLUSH    = 3'd4
  } sched_state_e;

endpackage

// File: rtl/cpu_thread_sched_rr_pick.sv
// Combinational round-robin priority encoder: searches last+1, last+2, ...
// with last itself checked at the end. N must be a power of two.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         valid
);

  logic [W-1:0] idx;

  always_comb begin
    grant = last;
    valid = 1'b0;
    idx   = last;
    // W-bit overflow provides the wrap; i == N lands back on last.
    for (int i = 1; i <= N; i++) begin
      idx = last + W'(i);
      if (!valid && req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_thread_sched.sv
// Round-robin thread scheduler: selects the next ready thread, drives the
// pipeline invalidate/reload pair and waits for the stage tracker's acknowledgement.
module cpu_thread_sched
  import cpu_thread_sched_pkg::*;
#(
  parameter int N_THREADS = SCHED_N_THREADS,
  parameter int THREAD_W  = SCHED_THREAD_W,
  parameter int CNT_W     = SCHED_CNT_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_THREADS-1:0] thread_ready,
  input  logic                 switch_req,
  input  logic                 thread_almost_switched,
  output logic                 invalidate,
  output logic                 reload,
  output logic [THREAD_W-1:0]  thread_num,
  output logic                 running,
  output logic                 idle,
  output logic [CNT_W-1:0]     switch_cnt,
  output sched_state_e         state_dbg
);

  // Handshake: a one-cycle reload pulse starts a thread; the scheduler then
  // holds in WAIT_ACK until thread_almost_switched is seen high on a clock edge.
  // switch_req is a single-cycle pulse and is never dropped once a reload is issued.

  sched_state_e          state_q, state_d;
  logic                  pending_q, pending_d;
  logic                  invalidate_d, reload_d, running_d, idle_d;
  logic [THREAD_W-1:0]   thread_num_d;
  logic [CNT_W-1:0]      switch_cnt_d;
  logic [THREAD_W-1:0]   pick_grant;
  logic                  pick_valid;
  logic                  yield;

  rr_pick #(
    .N (N_THREADS),
    .W (THREAD_W)
  ) u_rr_pick (
    .req   (thread_ready),
    .last  (thread_num),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // A thread losing its ready flag behaves exactly like an explicit yield.
  assign yield     = switch_req | pending_q | ~thread_ready[thread_num];
  assign state_dbg = state_q;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    invalidate_d = 1'b0;
    reload_d     = 1'b0;
    running_d    = running;
    idle_d       = idle;
    thread_num_d = thread_num;
    switch_cnt_d = switch_cnt;
    case (state_q)
      ST_IDLE, ST_FLUSH: begin
        if (pick_valid) begin
          thread_num_d = pick_grant;
          reload_d     = 1'b1;
          idle_d       = 1'b0;
          state_d      = ST_RELOAD;
        end else begin
          idle_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RELOAD: begin
        if (switch_req) pending_d = 1'b1;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (switch_req) pending_d = 1'b1;
        if (thread_almost_switched) begin
          running_d    = 1'b1;
          switch_cnt_d = switch_cnt + CNT_W'(1);
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (yield) begin
          invalidate_d = 1'b1;
          running_d    = 1'b0;
          pending_d    = 1'b0;
          state_d      = ST_FLUSH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      invalidate <= 1'b0;
      reload     <= 1'b0;
      running    <= 1'b0;
      idle       <= 1'b1;
      thread_num <= THREAD_W'(N_THREADS - 1);
      switch_cnt <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      invalidate <= invalidate_d;
      reload     <= reload_d;
      running    <= running_d;
      idle       <= idle_d;
      thread_num <= thread_num_d;
      switch_cnt <= switch_cnt_d;
    end
  end

endmodule

// File: tb/tb_cpu_thread_sched.sv
// Bench for cpu_thread_sched: directed scenarios plus randomized traffic
// compared against a behavioural model of the scheduler.
module tb_cpu_thread_sched;

  localparam int NT = 4;

  logic        CLK;
  logic        RST;
  logic [3:0]  thread_ready;
  logic        switch_req;
  logic        thread_almost_switched;
  logic        invalidate;
  logic        reload;
  logic [1:0]  thread_num;
  logic        running;
  logic        idle;
  logic [15:0] switch_cnt;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  cpu_thread_sched dut (
    .CLK                    (CLK),
    .RST                    (RST),
    .thread_ready           (thread_ready),
    .switch_req             (switch_req),
    .thread_almost_switched (thread_almost_switched),
    .invalidate             (invalidate),
    .reload                 (reload),
    .thread_num             (thread_num),
    .running                (running),
    .idle                   (idle),
    .switch_cnt             (switch_cnt),
    .state_dbg              (state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // driver helpers
  task automatic cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic logic [5:0] obs();
    return {invalidate, reload, running, idle, thread_num};
  endfunction

  function automatic logic [5:0] mk(bit inv, bit rl, bit run, bit idl, int t);
    return {inv, rl, run, idl, 2'(t)};
  endfunction

  // behavioural reference model
  int m_cur, m_cnt;
  bit m_idle, m_reload, m_wait, m_run, m_flush, m_pend;

  task automatic model_reset();
    m_cur = NT - 1; m_cnt = 0;
    m_idle = 1; m_reload = 0; m_wait = 0; m_run = 0; m_flush = 0; m_pend = 0;
  endtask

  task automatic model_step();
    bit found;
    int nxt;
    found = 0;
    nxt   = m_cur;
    if (m_idle || m_flush) begin
      for (int k = 1; k <= NT; k++) begin
        if (!found && thread_ready[(m_cur + k) % NT]) begin
          found = 1;
          nxt   = (m_cur + k) % NT;
        end
      end
      m_flush = 0;
      if (found) begin
        m_cur = nxt; m_idle = 0; m_reload = 1;
      end else begin
        m_idle = 1;
      end
    end else if (m_reload) begin
      m_reload = 0; m_wait = 1;
      if (switch_req) m_pend = 1;
    end else if (m_wait) begin
      if (switch_req) m_pend = 1;
      if (thread_almost_switched) begin
        m_wait = 0; m_run = 1; m_cnt = (m_cnt + 1) % 65536;
      end
    end else if (m_run) begin
      if (switch_req || m_pend || !thread_ready[m_cur]) begin
        m_run = 0; m_flush = 1; m_pend = 0;
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    logic [5:0] e;
    RST = 1; thread_ready = '0; switch_req = 0; thread_almost_switched = 0;
    cycle(); cycle();
    e = mk(0, 0, 0, 1, 3);
    n_checks++;
    if (obs() !== e) $display("FAIL reset_outputs: got %b want %b", obs(), e); else n_pass++;
    n_checks++;
    if (switch_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", switch_cnt); else n_pass++;
    RST = 0;
  endtask

  task automatic test_first_pick();
    logic [5:0] e;
    cycle(); cycle(); cycle();
    e = mk(0, 0, 0, 1, 3);
    n_checks++;
    if (obs() !== e) $display("FAIL idle_hold: got %b want %b", obs(), e); else n_pass++;
    thread_ready = 4'b0001;
    cycle();
    e = mk(0, 1, 0, 0, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL first_reload: got %b want %b", obs(), e); else n_pass++;
    cycle(); cycle();
    e = mk(0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL first_wait: got %b want %b", obs(), e); else n_pass++;
    thread_almost_switched = 1; cycle(); thread_almost_switched = 0;
    e = mk(0, 0, 1, 0, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL first_run: got %b want %b", obs(), e); else n_pass++;
    n_checks++;
    if (switch_cnt !== 16'd1) $display("FAIL first_cnt: got %0d want 1", switch_cnt); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [5:0] e;
    thread_ready = 4'b1111;
    for (int k = 1; k <= 4; k++) begin
      switch_req = 1; cycle(); switch_req = 0;
      e = mk(1, 0, 0, 0, (k - 1) % 4);
      n_checks++;
      if (obs() !== e) $display("FAIL rr_flush%0d: got %b want %b", k, obs(), e); else n_pass++;
      cycle();
      e = mk(0, 1, 0, 0, k % 4);
      n_checks++;
      if (obs() !== e) $display("FAIL rr_reload%0d: got %b want %b", k, obs(), e); else n_pass++;
      cycle();
      thread_almost_switched = 1; cycle(); thread_almost_switched = 0;
      e = mk(0, 0, 1, 0, k % 4);
      n_checks++;
      if (obs() !== e) $display("FAIL rr_run%0d: got %b want %b", k, obs(), e); else n_pass++;
      n_checks++;
      if (switch_cnt !== 16'(1 + k)) $display("FAIL rr_cnt%0d: got %0d want %0d", k, switch_cnt, 1 + k);
      else n_pass++;
    end
  endtask

  task automatic test_sole_ready();
    logic [5:0] e;
    thread_ready = 4'b0100;
    cycle();
    e = mk(1, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL drop_flush: got %b want %b", obs(), e); else n_pass++;
    cycle();
    e = mk(0, 1, 0, 0, 2);
    n_checks++;
    if (obs() !== e) $display("FAIL drop_reload: got %b want %b", obs(), e); else n_pass++;
    cycle();
    thread_almost_switched = 1; cycle(); thread_almost_switched = 0;
    switch_req = 1; cycle(); switch_req = 0;
    e = mk(1, 0, 0, 0, 2);
    n_checks++;
    if (obs() !== e) $display("FAIL sole_flush: got %b want %b", obs(), e); else n_pass++;
    cycle();
    e = mk(0, 1, 0, 0, 2);
    n_checks++;
    if (obs() !== e) $display("FAIL sole_reload: got %b want %b", obs(), e); else n_pass++;
    cycle();
    thread_almost_switched = 1; cycle(); thread_almost_switched = 0;
    n_checks++;
    if (switch_cnt !== 16'd7) $display("FAIL sole_cnt: got %0d want 7", switch_cnt); else n_pass++;
  endtask

  task automatic test_pending();
    logic [5:0] e;
    thread_ready = 4'b0010;
    cycle(); cycle();
    e = mk(0, 1, 0, 0, 1);
    n_checks++;
    if (obs() !== e) $display("FAIL pend_reload1: got %b want %b", obs(), e); else n_pass++;
    thread_ready = 4'b1111;
    cycle();
    switch_req = 1; cycle(); switch_req = 0;
    e = mk(0, 0, 0, 0, 1);
    n_checks++;
    if (obs() !== e) $display("FAIL pend_waiting: got %b want %b", obs(), e); else n_pass++;
    thread_almost_switched = 1; cycle(); thread_almost_switched = 0;
    e = mk(0, 0, 1, 0, 1);
    n_checks++;
    if (obs() !== e) $display("FAIL pend_run: got %b want %b", obs(), e); else n_pass++;
    cycle();
    e = mk(1, 0, 0, 0, 1);
    n_checks++;
    if (obs() !== e) $display("FAIL pend_flush: got %b want %b", obs(), e); else n_pass++;
    cycle();
    e = mk(0, 1, 0, 0, 2);
    n_checks++;
    if (obs() !== e) $display("FAIL pend_reload2: got %b want %b", obs(), e); else n_pass++;
    cycle();
    // yield and acknowledgement on the same edge
    switch_req = 1; thread_almost_switched = 1; cycle();
    switch_req = 0; thread_almost_switched = 0;
    e = mk(0, 0, 1, 0, 2);
    n_checks++;
    if (obs() !== e) $display("FAIL simul_run: got %b want %b", obs(), e); else n_pass++;
    cycle();
    e = mk(1, 0, 0, 0, 2);
    n_checks++;
    if (obs() !== e) $display("FAIL simul_flush: got %b want %b", obs(), e); else n_pass++;
    cycle();
    e = mk(0, 1, 0, 0, 3);
    n_checks++;
    if (obs() !== e) $display("FAIL simul_reload: got %b want %b", obs(), e); else n_pass++;
    cycle();
    thread_almost_switched = 1; cycle(); thread_almost_switched = 0;
    n_checks++;
    if (switch_cnt !== 16'd10) $display("FAIL simul_cnt: got %0d want 10", switch_cnt); else n_pass++;
  endtask

  task automatic test_ready_drop();
    logic [5:0] e;
    thread_ready = 4'b0000;
    cycle();
    e = mk(1, 0, 0, 0, 3);
    n_checks++;
    if (obs() !== e) $display("FAIL none_flush: got %b want %b", obs(), e); else n_pass++;
    cycle(); cycle();
    e = mk(0, 0, 0, 1, 3);
    n_checks++;
    if (obs() !== e) $display("FAIL none_idle: got %b want %b", obs(), e); else n_pass++;
    thread_ready = 4'b0001;
    cycle();
    e = mk(0, 1, 0, 0, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL wake_reload: got %b want %b", obs(), e); else n_pass++;
    cycle();
  endtask

  task automatic test_reset_mid();
    logic [5:0] e;
    RST = 1;
    #1;
    e = mk(0, 0, 0, 1, 3);
    n_checks++;
    if (obs() !== e) $display("FAIL async_reset: got %b want %b", obs(), e); else n_pass++;
    n_checks++;
    if (switch_cnt !== 16'd0) $display("FAIL async_reset_cnt: got %0d want 0", switch_cnt); else n_pass++;
    @(negedge CLK);
    thread_ready = '0;
    cycle();
    RST = 0;
  endtask

  task automatic test_random();
    logic [5:0] e;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0)
        thread_ready = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      switch_req             = ($urandom_range(0, 4) == 0);
      thread_almost_switched = ($urandom_range(0, 2) == 0);
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      e = mk(m_flush, m_reload, m_run, m_idle, m_cur);
      n_checks++;
      if (obs() !== e) $display("FAIL rand_outputs c%0d: got %b want %b", c, obs(), e); else n_pass++;
      n_checks++;
      if (switch_cnt !== 16'(m_cnt)) $display("FAIL rand_cnt c%0d: got %0d want %0d", c, switch_cnt, m_cnt);
      else n_pass++;
      n_checks++;
      if (invalidate && reload) $display("FAIL rand_exclusive c%0d: got inv=1 rl=1 want not both", c);
      else n_pass++;
    end
    switch_req = 0;
    thread_almost_switched = 0;
  endtask

  // sequence and report
  initial begin
    test_reset();
    test_first_pick();
    test_round_robin();
    test_sole_ready();
    test_pending();
    test_ready_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
